// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: HI/LO owner and sequencer for the EX-stage multiplier and divider.
// Optional MULDIV_HILO_BYPASS_EN forwards same-cycle HI/LO writes onto hi_o/lo_o.
module muldiv_ctrl #(
    parameter int MUL_LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        op_valid,
    input  logic [2:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        flush,
    output logic        stallreq,
    output logic        busy,
    output logic        mul_signed,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    input  logic [63:0] mul_result,
    output logic        div_start,
    output logic        div_annul,
    output logic        div_signed,
    output logic [31:0] div_a,
    output logic [31:0] div_b,
    input  logic        div_ready,
    input  logic [63:0] div_result,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    typedef enum logic [1:0] {
        IDLE,
        MUL_WAIT,
        DIV_WAIT,
        DONE
    } state_t;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;
    localparam logic [3:0] LAT      = 4'(MUL_LAT);

    state_t      state;
    logic [3:0]  cnt;
    logic [31:0] hi;
    logic [31:0] lo;

    logic accept;
    logic is_mul;
    logic is_div;
    logic is_mthi;
    logic is_mtlo;
    logic mul_wr;
    logic div_wr;

    // Decode of the instruction offered by EX and of this cycle's HI/LO commits.
    always_comb begin
        accept  = (state == IDLE) && op_valid && !flush;
        is_mul  = accept && ((op == OP_MULT) || (op == OP_MULTU));
        is_div  = accept && ((op == OP_DIV) || (op == OP_DIVU));
        is_mthi = accept && (op == OP_MTHI);
        is_mtlo = accept && (op == OP_MTLO);
        mul_wr  = (state == MUL_WAIT) && (cnt == 4'd1) && !flush;
        div_wr  = (state == DIV_WAIT) && div_ready && !flush;
    end

    // Pipeline-facing handshake; annul is suppressed under rst since the
    // divider is reset by the same signal.
    always_comb begin
        stallreq  = is_mul || is_div ||
                    (state == MUL_WAIT) || (state == DIV_WAIT);
        busy      = (state != IDLE);
        div_start = (state == DIV_WAIT) && !flush;
        div_annul = (state == DIV_WAIT) && flush && !rst;
    end

    // Sequencer: accept, wait on the unit, commit HI/LO, release EX.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            hi         <= '0;
            lo         <= '0;
            mul_signed <= 1'b0;
            mul_a      <= '0;
            mul_b      <= '0;
            div_signed <= 1'b0;
            div_a      <= '0;
            div_b      <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (is_mul) begin
                        mul_a      <= src_a;
                        mul_b      <= src_b;
                        mul_signed <= (op == OP_MULT);
                        cnt        <= LAT;
                        state      <= MUL_WAIT;
                    end else if (is_div) begin
                        if (src_b != 32'd0) begin
                            div_a      <= src_a;
                            div_b      <= src_b;
                            div_signed <= (op == OP_DIV);
                            state      <= DIV_WAIT;
                        end else begin
                            state <= DONE;
                        end
                    end else if (is_mthi) begin
                        hi <= src_a;
                    end else if (is_mtlo) begin
                        lo <= src_a;
                    end
                end
                MUL_WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (flush) begin
                        state <= IDLE;
                    end else if (mul_wr) begin
                        hi    <= mul_result[63:32];
                        lo    <= mul_result[31:0];
                        state <= DONE;
                    end
                end
                DIV_WAIT: begin
                    if (flush) begin
                        state <= IDLE;
                    end else if (div_wr) begin
                        hi    <= div_result[63:32];
                        lo    <= div_result[31:0];
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef MULDIV_HILO_BYPASS_EN
    // Forward the value being written this cycle so a same-cycle mfhi/mflo sees it.
    always_comb begin
        hi_o = hi;
        lo_o = lo;
        if (!rst) begin
            if (is_mthi) begin
                hi_o = src_a;
            end else if (mul_wr) begin
                hi_o = mul_result[63:32];
            end else if (div_wr) begin
                hi_o = div_result[63:32];
            end
            if (is_mtlo) begin
                lo_o = src_a;
            end else if (mul_wr) begin
                lo_o = mul_result[31:0];
            end else if (div_wr) begin
                lo_o = div_result[31:0];
            end
        end
    end
`else
    // Architectural HI/LO straight from the registers.
    always_comb begin
        hi_o = hi;
        lo_o = lo;
    end
`endif

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl: vector table plus hand sequences for muldiv_ctrl,
// with behavioural multiplier and start/ready divider models.
module tb_muldiv_ctrl;

    localparam int MUL_LAT = 2;

`ifdef MULDIV_HILO_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        op_valid;
    logic [2:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        flush;
    logic        stallreq;
    logic        busy;
    logic        mul_signed;
    logic [31:0] mul_a;
    logic [31:0] mul_b;
    logic [63:0] mul_result;
    logic        div_start;
    logic        div_annul;
    logic        div_signed;
    logic [31:0] div_a;
    logic [31:0] div_b;
    logic        div_ready;
    logic [63:0] div_result;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    muldiv_ctrl #(.MUL_LAT(MUL_LAT)) dut (
        .clk        (clk),
        .rst        (rst),
        .op_valid   (op_valid),
        .op         (op),
        .src_a      (src_a),
        .src_b      (src_b),
        .flush      (flush),
        .stallreq   (stallreq),
        .busy       (busy),
        .mul_signed (mul_signed),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_result (mul_result),
        .div_start  (div_start),
        .div_annul  (div_annul),
        .div_signed (div_signed),
        .div_a      (div_a),
        .div_b      (div_b),
        .div_ready  (div_ready),
        .div_result (div_result),
        .hi_o       (hi_o),
        .lo_o       (lo_o)
    );

    always #5 clk = ~clk;

    // Multiplier model: full 64-bit product of the latched operands.
    logic [63:0] ma;
    logic [63:0] mb;
    always_comb begin
        ma = mul_signed ? {{32{mul_a[31]}}, mul_a} : {32'd0, mul_a};
        mb = mul_signed ? {{32{mul_b[31]}}, mul_b} : {32'd0, mul_b};
        mul_result = ma * mb;
    end

    // Divider model: {remainder, quotient}, ready after div_lat held-start cycles.
    logic signed [31:0] sda;
    logic signed [31:0] sdb;
    always_comb begin
        sda = div_a;
        sdb = div_b;
        div_result = '0;
        if (div_b != 32'd0) begin
            if (div_signed) begin
                div_result = {32'(sda % sdb), 32'(sda / sdb)};
            end else begin
                div_result = {div_a % div_b, div_a / div_b};
            end
        end
    end

    int div_lat = 33;
    int dcnt = 0;
    always @(posedge clk) begin
        if (rst || div_annul || !div_start) dcnt <= 0;
        else dcnt <= dcnt + 1;
    end
    assign div_ready = (dcnt == div_lat);

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
    } hl_t;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          stall;
        int          ds;
    } vec_t;

    hl_t  sb_q[$];
    hl_t  cur;
    vec_t vt[13];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [2:0] o, input logic [31:0] a,
                                input logic [31:0] b, input logic [31:0] h,
                                input logic [31:0] l, input int s,
                                input int d);
        vec_t v;
        v.op = o; v.a = a; v.b = b;
        v.hi = h; v.lo = l; v.stall = s; v.ds = d;
        return v;
    endfunction

    task automatic run_vec(input int idx, input vec_t v);
        int  n;
        int  ds;
        hl_t e;
        @(negedge clk);
        op_valid = 1'b1;
        op = v.op;
        src_a = v.a;
        src_b = v.b;
        sb_q.push_back('{hi: v.hi, lo: v.lo});
        n = 0;
        ds = 0;
        #1;
        while (stallreq && n < 400) begin
            if (div_start) ds++;
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 400) begin
            n_cmp++;
            n_bad++;
            $display("FAIL vec%0d timeout: stallreq still 1 after %0d cycles", idx, n);
        end
        chk($sformatf("vec%0d stall_cycles", idx), 64'(n), 64'(v.stall));
        chk($sformatf("vec%0d div_start_cycles", idx), 64'(ds), 64'(v.ds));
        if (v.stall > 0) begin
            e = sb_q.pop_front();
            chk($sformatf("vec%0d busy_done", idx), 64'(busy), 64'd1);
            chk($sformatf("vec%0d hilo_done", idx), {hi_o, lo_o}, e);
        end else begin
            chk($sformatf("vec%0d hilo_same", idx), {hi_o, lo_o},
                BYP ? {v.hi, v.lo} : cur);
        end
        @(negedge clk);
        op_valid = 1'b0;
        #1;
        if (v.stall == 0) e = sb_q.pop_front();
        chk($sformatf("vec%0d busy_after", idx), 64'(busy), 64'd0);
        chk($sformatf("vec%0d hilo_after", idx), {hi_o, lo_o}, e);
        cur = e;
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int k;
        vt[0]  = mk(3'b000, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFE, 3, 0);
        vt[1]  = mk(3'b001, 32'hFFFFFFFF, 32'd2, 32'h00000001, 32'hFFFFFFFE, 3, 0);
        vt[2]  = mk(3'b011, 32'd100, 32'd7, 32'd2, 32'd14, 35, 34);
        vt[3]  = mk(3'b010, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFF2, 35, 34);
        vt[4]  = mk(3'b100, 32'h11, 32'd0, 32'h11, 32'hFFFFFFF2, 0, 0);
        vt[5]  = mk(3'b101, 32'h22, 32'd0, 32'h11, 32'h22, 0, 0);
        vt[6]  = mk(3'b010, 32'd5, 32'd0, 32'h11, 32'h22, 1, 0);
        vt[7]  = mk(3'b011, 32'hFFFFFFFF, 32'd0, 32'h11, 32'h22, 1, 0);
        vt[8]  = mk(3'b110, 32'h55, 32'd1, 32'h11, 32'h22, 0, 0);
        vt[9]  = mk(3'b111, 32'h66, 32'd1, 32'h11, 32'h22, 0, 0);
        vt[10] = mk(3'b000, 32'h7FFFFFFF, 32'h80000000, 32'hC0000000, 32'h80000000, 3, 0);
        vt[11] = mk(3'b001, 32'h7FFFFFFF, 32'h80000000, 32'h3FFFFFFF, 32'h80000000, 3, 0);
        vt[12] = mk(3'b010, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, 35, 34);

        rst = 1'b1;
        op_valid = 1'b0;
        op = 3'b000;
        src_a = '0;
        src_b = '0;
        flush = 1'b0;
        cur = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset ctl", {58'd0, stallreq, busy, div_start, div_annul,
                          mul_signed, div_signed}, 64'd0);
        chk("reset hilo", {hi_o, lo_o}, 64'd0);
        chk("reset mul ops", {mul_a, mul_b}, 64'd0);
        chk("reset div ops", {div_a, div_b}, 64'd0);

        for (int i = 0; i < 13; i++) run_vec(i, vt[i]);

        // divide flushed ten cycles after acceptance
        @(negedge clk);
        op_valid = 1'b1; op = 3'b011; src_a = 32'd1000; src_b = 32'd3;
        repeat (10) @(negedge clk);
        flush = 1'b1;
        #1;
        chk("flush10 annul", 64'(div_annul), 64'd1);
        chk("flush10 start", 64'(div_start), 64'd0);
        @(negedge clk);
        flush = 1'b0; op_valid = 1'b0;
        #1;
        chk("flush10 busy", 64'(busy), 64'd0);
        chk("flush10 annul_off", 64'(div_annul), 64'd0);
        chk("flush10 hilo", {hi_o, lo_o}, cur);

        // flush in the same cycle as div_ready
        div_lat = 3;
        @(negedge clk);
        op_valid = 1'b1; op = 3'b011; src_a = 32'd50; src_b = 32'd4;
        k = 0;
        do begin
            @(negedge clk);
            #1;
            k++;
        end while (!div_ready && k < 20);
        chk("flushrdy ready_seen", 64'(div_ready), 64'd1);
        flush = 1'b1;
        #1;
        chk("flushrdy annul", 64'(div_annul), 64'd1);
        @(negedge clk);
        flush = 1'b0; op_valid = 1'b0;
        #1;
        chk("flushrdy busy", 64'(busy), 64'd0);
        chk("flushrdy hilo", {hi_o, lo_o}, cur);

        // flush during MUL_WAIT
        @(negedge clk);
        op_valid = 1'b1; op = 3'b000; src_a = 32'd7; src_b = 32'd9;
        @(negedge clk);
        flush = 1'b1; op_valid = 1'b0;
        @(negedge clk);
        flush = 1'b0;
        #1;
        chk("mulflush busy", 64'(busy), 64'd0);
        repeat (3) @(negedge clk);
        #1;
        chk("mulflush hilo", {hi_o, lo_o}, cur);

        // reset during MUL_WAIT
        @(negedge clk);
        op_valid = 1'b1; op = 3'b001; src_a = 32'd3; src_b = 32'd5;
        @(negedge clk);
        op_valid = 1'b0; rst = 1'b1;
        #1;
        chk("rstmul annul", 64'(div_annul), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rstmul busy_stall", {62'd0, busy, stallreq}, 64'd0);
        chk("rstmul hilo", {hi_o, lo_o}, 64'd0);
        chk("rstmul mul ops", {mul_a, mul_b}, 64'd0);
        repeat (3) @(negedge clk);
        #1;
        chk("rstmul hilo_later", {hi_o, lo_o}, 64'd0);

        // back-to-back mthi / mtlo
        @(negedge clk);
        op_valid = 1'b1; op = 3'b100; src_a = 32'hDEADBEEF;
        #1;
        chk("mthi stall", 64'(stallreq), 64'd0);
        chk("mthi hi_same", 64'(hi_o), BYP ? 64'hDEADBEEF : 64'd0);
        @(negedge clk);
        op = 3'b101; src_a = 32'h12345678;
        #1;
        chk("mtlo stall", 64'(stallreq), 64'd0);
        chk("mtlo hi_prev", 64'(hi_o), 64'hDEADBEEF);
        chk("mtlo lo_same", 64'(lo_o), BYP ? 64'h12345678 : 64'd0);
        @(negedge clk);
        op_valid = 1'b0;
        #1;
        chk("mthilo final", {hi_o, lo_o}, 64'hDEADBEEF_12345678);

        // mthi dropped by a same-cycle flush
        @(negedge clk);
        op_valid = 1'b1; op = 3'b100; src_a = 32'h0000CAFE; flush = 1'b1;
        #1;
        chk("flushmthi stall", 64'(stallreq), 64'd0);
        chk("flushmthi hi_same", 64'(hi_o), 64'hDEADBEEF);
        @(negedge clk);
        op_valid = 1'b0; flush = 1'b0;
        #1;
        chk("flushmthi hi_after", 64'(hi_o), 64'hDEADBEEF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
